// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window path.
//   CONV_SIZE : default window edge used by the conv datapath
//   DATA_W    : default pixel/word width
//   word_t    : one pixel word
//   win_idx   : flattened index of window element (r, c), r=0 top row, c=0 left column
package conv_pkg;

  localparam int CONV_SIZE = 7;
  localparam int DATA_W    = 32;

  typedef logic [DATA_W-1:0] word_t;

  function automatic int win_idx(input int r, input int c, input int size = CONV_SIZE);
    return r * size + c;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One-row delay line for the window generator.
// Circular buffer with a single pointer: dout is the word written DEPTH
// writes ago (read-before-write at the current pointer).
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset (pointer only; storage is not reset)
//   wr_en  : write din and advance the pointer
//   din    : word to store
//   dout   : word stored DEPTH writes ago
module conv_line_buffer #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int             PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]  PTR_MAX = PW'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (wr_en) begin
      ptr_d = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[ptr_q] <= din;
  end

  assign dout = mem_q[ptr_q];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming sliding-window generator feeding the conv FMA chain.
// Takes a raster-scan pixel stream and presents every complete SIZE x SIZE
// window (valid windows only, no padding) as a packed array, element
// r*SIZE+c with r=0 the oldest row and c=0 the leftmost column.
// Optional feature: define CONV_WIN_LAST_EN to add window_last, which flags
// the final window of each frame.
// Ports:
//   clk          : clock, rising edge
//   rst_n        : synchronous active-low reset
//   pix_in       : incoming pixel
//   pix_valid    : pix_in is valid
//   pix_ready    : block accepts pix_in this cycle
//   window_out   : current window
//   window_valid : window_out holds a complete window
//   window_ready : downstream consumes the window this cycle
//   window_last  : (CONV_WIN_LAST_EN only) final window of the frame
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int SIZE   = CONV_SIZE,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int DATA_W = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [DATA_W-1:0]                   pix_in,
  input  logic                                pix_valid,
  output logic                                pix_ready,
  output logic [SIZE*SIZE-1:0][DATA_W-1:0]    window_out,
  output logic                                window_valid,
`ifdef CONV_WIN_LAST_EN
  output logic                                window_last,
`endif
  input  logic                                window_ready
);

  localparam int            CW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int            RW      = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN = CW'(SIZE - 1);
  localparam logic [RW-1:0] ROW_MIN = RW'(SIZE - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          window_valid_q, window_valid_d;
  logic          window_last_q, window_last_d;
  logic [SIZE*SIZE-1:0][DATA_W-1:0] win_q, win_d;

  logic accept;
  logic qualify;
  logic frame_end;

  logic [DATA_W-1:0] lb_din  [SIZE-1];
  logic [DATA_W-1:0] lb_dout [SIZE-1];

  assign pix_ready = !window_valid_q || window_ready;
  assign accept    = pix_valid && pix_ready;
  // The pixel being accepted completes a window only once enough rows and
  // columns of the current frame exist; this also keeps previous-row and
  // previous-frame data in the line buffers from ever reaching the output.
  assign qualify   = (row_q >= ROW_MIN) && (col_q >= COL_MIN);
  assign frame_end = (row_q == ROW_MAX) && (col_q == COL_MAX);

  // Line buffer k delays by k+1 rows: each buffer feeds the next.
  for (genvar k = 0; k < SIZE - 1; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign lb_din[k] = pix_in;
    end else begin : g_chain
      assign lb_din[k] = lb_dout[k-1];
    end
    conv_line_buffer #(
      .DEPTH  (IMG_W),
      .DATA_W (DATA_W)
    ) u_lb (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (accept),
      .din   (lb_din[k]),
      .dout  (lb_dout[k])
    );
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE - 1; c++) begin
          win_d[win_idx(r, c, SIZE)] = win_q[win_idx(r, c + 1, SIZE)];
        end
      end
      // New right column: bottom row is the live pixel, rows above come
      // from progressively deeper line buffers.
      win_d[win_idx(SIZE - 1, SIZE - 1, SIZE)] = pix_in;
      for (int k = 0; k < SIZE - 1; k++) begin
        win_d[win_idx(SIZE - 2 - k, SIZE - 1, SIZE)] = lb_dout[k];
      end
    end
  end

  // An accept can only happen while the current window (if any) is being
  // consumed, so a non-qualifying accept also retires the old window.
  always_comb begin
    window_valid_d = window_valid_q && !window_ready;
    window_last_d  = window_valid_d && window_last_q;
    if (accept) begin
      window_valid_d = qualify;
      window_last_d  = qualify && frame_end;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q          <= '0;
      row_q          <= '0;
      window_valid_q <= 1'b0;
      window_last_q  <= 1'b0;
      win_q          <= '0;
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      window_valid_q <= window_valid_d;
      window_last_q  <= window_last_d;
      win_q          <= win_d;
    end
  end

  assign window_out   = win_q;
  assign window_valid = window_valid_q;
`ifdef CONV_WIN_LAST_EN
  assign window_last  = window_last_q;
`else
  logic unused_last;
  assign unused_last = window_last_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;

  localparam int SIZE  = 3;
  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int DW    = 32;
  localparam int NW    = SIZE * SIZE;
  localparam int WB    = NW * DW;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [DW-1:0]           pix_in = '0;
  logic                    pix_valid = 1'b0;
  logic                    pix_ready;
  logic [NW-1:0][DW-1:0]   window_out;
  logic                    window_valid;
  logic                    window_ready = 1'b0;
`ifdef CONV_WIN_LAST_EN
  logic                    window_last;
`endif

  always #5 clk = ~clk;

  conv_window_gen #(
    .SIZE   (SIZE),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .DATA_W (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix_in       (pix_in),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .window_out   (window_out),
    .window_valid (window_valid),
`ifdef CONV_WIN_LAST_EN
    .window_last  (window_last),
`endif
    .window_ready (window_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the frame image so far, the position of the next pixel
  // to send, and the queue of windows the block still owes downstream.
  int                gf, gr, gc;
  int                img [IMG_H][IMG_W];
  logic [WB-1:0]     exp_q [$];
  bit                last_q [$];
  int                win_cnt;
  int                acc_cnt;

  function automatic logic [WB-1:0] mk_win(input int base);
    logic [WB-1:0] v;
    v = '0;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        v[(r*SIZE+c)*DW +: DW] = DW'(base + r*IMG_W + c);
    return v;
  endfunction

  function automatic logic [WB-1:0] win_from_img(input int r0, input int c0);
    logic [WB-1:0] v;
    v = '0;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        v[(r*SIZE+c)*DW +: DW] = DW'(img[r0+r][c0+c]);
    return v;
  endfunction

  // One clock: called at a falling edge, returns at the next falling edge.
  task automatic step(input bit pv, input bit wr);
    bit acc, cons;
    int val;
    val = gf*20 + gr*5 + gc;
    pix_valid    = pv;
    window_ready = wr;
    pix_in       = DW'(val);
    #1;
    check_eq("pix_ready", WB'(pix_ready), WB'((exp_q.size() == 0) || wr));
    acc  = pv && ((exp_q.size() == 0) || wr);
    cons = (exp_q.size() != 0) && wr;
    @(posedge clk);
    if (cons) begin
      void'(exp_q.pop_front());
      void'(last_q.pop_front());
      win_cnt++;
    end
    if (acc) begin
      img[gr][gc] = val;
      if (gr >= SIZE-1 && gc >= SIZE-1) begin
        exp_q.push_back(win_from_img(gr-SIZE+1, gc-SIZE+1));
        last_q.push_back(gr == IMG_H-1 && gc == IMG_W-1);
      end
      acc_cnt++;
      gc++;
      if (gc == IMG_W) begin
        gc = 0;
        gr++;
        if (gr == IMG_H) begin
          gr = 0;
          gf++;
        end
      end
    end
    @(negedge clk);
    check_eq("win_valid", WB'(window_valid), WB'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check_eq("win_data", window_out, exp_q[0]);
`ifdef CONV_WIN_LAST_EN
      check_eq("win_last", WB'(window_last), WB'(last_q[0]));
`endif
    end
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    pix_valid    = 1'b0;
    window_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    last_q.delete();
    gf = 0; gr = 0; gc = 0;
    win_cnt = 0; acc_cnt = 0;
    #1;
    check_eq("rst_valid", WB'(window_valid), '0);
    check_eq("rst_ready", WB'(pix_ready), WB'(1));
    check_eq("rst_window", window_out, '0);
`ifdef CONV_WIN_LAST_EN
    check_eq("rst_last", WB'(window_last), '0);
`endif
    @(negedge clk);
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1);
  endtask

  initial begin
    @(negedge clk);

    // First window and single-frame window count
    do_reset();
    stream(13);
    check_eq("first_valid", WB'(window_valid), WB'(1));
    check_eq("first_window", window_out, mk_win(0));
    stream(7);
    step(1'b0, 1'b1);
    check_eq("frame_windows", WB'(win_cnt), WB'(6));
    stream(7);
    check_eq("straddle_none", WB'(window_valid), '0);

    // Backpressure at the first window
    do_reset();
    stream(13);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      check_eq("bp_ready", WB'(pix_ready), '0);
      check_eq("bp_window", window_out, mk_win(0));
    end
    step(1'b1, 1'b1);
    check_eq("bp_next_idx8", WB'(window_out[8]), WB'(13));
    stream(6);
    step(1'b0, 1'b1);
    check_eq("bp_windows", WB'(win_cnt), WB'(6));

    // Back-to-back frames
    do_reset();
    stream(33);
    check_eq("f2_first_window", window_out, mk_win(20));
    stream(7);
    step(1'b0, 1'b1);
    check_eq("two_frame_windows", WB'(win_cnt), WB'(12));

    // Reset mid-frame
    do_reset();
    stream(14);
    check_eq("mid_valid", WB'(window_valid), WB'(1));
    do_reset();
    stream(13);
    check_eq("restart_window", window_out, mk_win(0));

    // Random valid/ready over three frames
    do_reset();
    for (int i = 0; i < 4000 && acc_cnt < 3*IMG_W*IMG_H; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    check_eq("rand_accepts", WB'(acc_cnt), WB'(3*IMG_W*IMG_H));
    check_eq("rand_windows", WB'(win_cnt), WB'(18));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
